// File: rtl/dmem_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_access_ctrl_pkg
// Description : Constants shared by the MEM-stage data-memory sequencer.
//               Holds the datapath width, the access-width lane codes and
//               the sequencer state encodings. Also provides a helper that
//               checks whether a lane code is one of the four legal widths.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_access_ctrl_pkg;

    // Datapath width. Must match the pipeline-wide data width.
    localparam int c_XLEN = 64;

    // Access-width lane codes, right-justified (unshifted) byte masks.
    localparam logic [7:0] c_W_B = 8'h01;
    localparam logic [7:0] c_W_H = 8'h03;
    localparam logic [7:0] c_W_W = 8'h0F;
    localparam logic [7:0] c_W_D = 8'hFF;

    // Sequencer state encodings.
    localparam int         c_STATE_W = 2;
    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_REQ   = 2'd1;
    localparam logic [1:0] c_S_WAIT  = 2'd2;
    localparam logic [1:0] c_S_DONE  = 2'd3;

    // True when the lane code is one of B/H/W/D.
    function automatic logic width_legal(input logic [7:0] i_w);
        return (i_w == c_W_B) || (i_w == c_W_H) ||
               (i_w == c_W_W) || (i_w == c_W_D);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_access_ctrl_load_extend.sv
`default_nettype none
// ============================================================================
// Module      : dmem_access_ctrl_load_extend
// Description : Combinational load formatter. Extracts the addressed bytes
//               from a full memory line and sign- or zero-extends them to
//               XLEN bits.
//   i_rdata       full line returned by memory
//   i_off         byte offset of the access within the line
//   i_width       access-width lane code (B/H/W/D)
//   i_unsigned    1 = zero-extend, 0 = sign-extend
//   o_ext         extended load value
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_access_ctrl_load_extend
    import dmem_access_ctrl_pkg::*;
#(
    parameter int XLEN = c_XLEN
) (
    input  logic [XLEN-1:0] i_rdata,
    input  logic [2:0]      i_off,
    input  logic [7:0]      i_width,
    input  logic            i_unsigned,
    output logic [XLEN-1:0] o_ext
);

    logic [XLEN-1:0] w_shifted;

    always_comb begin
        // Bring the addressed byte down to lane 0, then trim and extend.
        w_shifted = i_rdata >> {i_off, 3'b000};
        o_ext     = w_shifted;
        case (i_width)
            c_W_B: o_ext = {{(XLEN-8){~i_unsigned & w_shifted[7]}},
                            w_shifted[7:0]};
            c_W_H: o_ext = {{(XLEN-16){~i_unsigned & w_shifted[15]}},
                            w_shifted[15:0]};
            c_W_W: o_ext = {{(XLEN-32){~i_unsigned & w_shifted[31]}},
                            w_shifted[31:0]};
            default: o_ext = w_shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_access_ctrl
// Description : MEM-stage data-memory access sequencer. Accepts the load /
//               store controls leaving EX/MEM, checks alignment, drives a
//               single-ported XLEN-bit memory over a req/gnt/rvalid
//               handshake, and stalls the pipeline until the access is done.
//   sys_clk / sys_rst      clock, synchronous active-high reset
//   mem_*                  MEM-stage request (valid, write, read, lane code,
//                          unsigned, byte address, right-justified data)
//   stall                  hold pipeline registers this cycle
//   load_data/load_valid   extended load result and its 1-cycle strobe
//   misalign               1-cycle strobe: access rejected, nothing issued
//   dmem_req/we/addr/be/wdata   memory request side
//   dmem_gnt/rvalid/rdata       memory response side
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int XLEN   = c_XLEN,
    parameter int ADDR_W = 32
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              mem_valid,
    input  logic              mem_is_write_dmem,
    input  logic              mem_is_read_dmem,
    input  logic [7:0]        mem_width,
    input  logic              mem_load_unsigned,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [XLEN-1:0]   mem_wdata,
    output logic              stall,
    output logic [XLEN-1:0]   load_data,
    output logic              load_valid,
    output logic              misalign,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [7:0]        dmem_be,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata
);

    // ------------------------------------------------------------------
    // State and captured request
    // ------------------------------------------------------------------
    logic [c_STATE_W-1:0] r_state;
    logic                 r_we;
    logic [7:0]           r_be;
    logic [ADDR_W-1:0]    r_addr;
    logic [XLEN-1:0]      r_wdata;
    logic [2:0]           r_off;
    logic [7:0]           r_width;
    logic                 r_unsigned;
    logic [XLEN-1:0]      r_load_data;
    logic                 r_load_valid;

    // ------------------------------------------------------------------
    // Alignment check on the incoming request (only meaningful in IDLE)
    // ------------------------------------------------------------------
    logic                 w_access;
    logic [2:0]           w_off;
    logic [15:0]          w_be16;
    logic                 w_misaligned;
    logic                 w_idle;
    logic                 w_start;
    logic                 w_reject;
    logic [XLEN-1:0]      w_store_data;
    logic [XLEN-1:0]      w_load_ext;

    assign w_access     = mem_valid & (mem_is_write_dmem | mem_is_read_dmem);
    assign w_off        = mem_addr[2:0];
    // Shifting into a 16-bit window exposes any lane that would spill past
    // the end of the 8-byte line.
    assign w_be16       = {8'h00, mem_width} << w_off;
    assign w_misaligned = ~width_legal(mem_width) | (w_be16[15:8] != 8'h00);
    assign w_idle       = (r_state == c_S_IDLE);
    assign w_start      = w_idle & w_access & ~w_misaligned;
    assign w_reject     = w_idle & w_access &  w_misaligned;
    assign w_store_data = mem_wdata << {w_off, 3'b000};

    dmem_access_ctrl_load_extend #(
        .XLEN       (XLEN)
    ) u_load_extend (
        .i_rdata    (dmem_rdata),
        .i_off      (r_off),
        .i_width    (r_width),
        .i_unsigned (r_unsigned),
        .o_ext      (w_load_ext)
    );

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state      <= c_S_IDLE;
            r_we         <= 1'b0;
            r_be         <= 8'h00;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_off        <= 3'd0;
            r_width      <= 8'h00;
            r_unsigned   <= 1'b0;
            r_load_data  <= '0;
            r_load_valid <= 1'b0;
        end else begin
            r_load_valid <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (w_start) begin
                        // A request with both read and write set is a store.
                        r_we       <= mem_is_write_dmem;
                        r_be       <= w_be16[7:0];
                        r_addr     <= {mem_addr[ADDR_W-1:3], 3'b000};
                        r_wdata    <= w_store_data;
                        r_off      <= w_off;
                        r_width    <= mem_width;
                        r_unsigned <= mem_load_unsigned;
                        r_state    <= c_S_REQ;
                    end
                end
                c_S_REQ: begin
                    if (dmem_gnt) begin
                        r_state <= r_we ? c_S_DONE : c_S_WAIT;
                    end
                end
                c_S_WAIT: begin
                    if (dmem_rvalid) begin
                        r_load_data  <= w_load_ext;
                        r_load_valid <= 1'b1;
                        r_state      <= c_S_DONE;
                    end
                end
                c_S_DONE: begin
                    // Pipeline advances this cycle; the still-presented
                    // request is the one just completed and is not reissued.
                    r_state <= c_S_IDLE;
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Stall asserts combinationally in IDLE so the accepting cycle already
    // holds the pipeline; REQ and WAIT hold it until the access completes.
    assign stall      = w_start | (r_state == c_S_REQ) | (r_state == c_S_WAIT);
    assign misalign   = w_reject;
    assign dmem_req   = (r_state == c_S_REQ);
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_be    = r_be;
    assign dmem_wdata = r_wdata;
    assign load_data  = r_load_data;
    assign load_valid = r_load_valid;

endmodule
`default_nettype wire
